// File: rtl/fram_arb_pkg.sv
// Shared types and helpers for the two-port FRAM arbiter.
package fram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Winner selection. In round-robin mode a tie goes to the port that did
  // not win last time; a lone requester always wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last, input logic fixed);
    logic w;
    if (fixed || !(r0 && r1)) w = r0 ? PORT_CPU : PORT_AUX;
    else                      w = ~last;
    return w;
  endfunction

endpackage

// File: rtl/fram_arbiter.sv
// Shares one SPI FRAM port between the CPU (port 0) and an auxiliary master
// (port 1). One whole transaction is granted at a time; the winning request
// is latched so the requester may change its inputs once it has been issued.
module fram_arbiter
  import fram_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_start,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic          err_timeout,
  input  logic          err_clr
);

  // Counter wide enough to hold TIMEOUT; one bit when the timeout is disabled.
  localparam int          CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic          start_q, start_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          win;
  logic          tmo_set;

  assign win = pick_winner(req0, req1, last_q, FIXED_PRIO != 0);

  // Next-state logic for the FSM, latch registers and wait counter.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tmo_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_ISSUE;
          start_d = 1'b1;
          grant_d = win;
          last_d  = win;
          we_d    = win ? we1    : we0;
          addr_d  = win ? addr1  : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // Saturating count; the flag fires once, on the step that reaches TMAX.
        if (cnt_q != TMAX) begin
          cnt_d   = cnt_q + CW'(1);
          tmo_set = (TIMEOUT != 0) && (cnt_d == TMAX);
        end
        if (mem_done) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          if (grant_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    // A new timeout beats a simultaneous clear.
    if (tmo_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
      grant_q  <= PORT_CPU;
      last_q   <= PORT_AUX;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign mem_start   = start_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fram_arbiter.sv
// Directed bench for fram_arbiter: a round-robin instance with a short
// timeout, and a fixed-priority instance sharing the same stimulus.
module tb_fram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0, err_clr = 0;
  logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic        mem_done = 0;
  logic [15:0] mem_rdata;

  logic        ack0, ack1, mem_start, mem_we, busy, grant_id, err_timeout;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic        ack0_fp, ack1_fp, mem_start_fp, mem_we_fp, busy_fp, grant_id_fp, err_fp;
  logic [15:0] rdata0_fp, rdata1_fp, mem_addr_fp, mem_wdata_fp;

  int          n_chk = 0, n_fail = 0;
  int          mem_lat = 5;
  logic [15:0] rd_val = 16'h0;
  int          rcnt = 0;
  int          starts = 0, ack0s = 0, ack1s = 0;
  logic [15:0] last_addr = 0, last_wdata = 0;
  logic        last_we = 0;
  logic        gq[$];
  logic        gq_fp[$];

  always #5 clk = ~clk;

  fram_arbiter #(.AW(16), .DW(16), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  fram_arbiter #(.AW(16), .DW(16), .FIXED_PRIO(1), .TIMEOUT(4096)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0_fp), .rdata0(rdata0_fp), .ack1(ack1_fp), .rdata1(rdata1_fp),
    .mem_start(mem_start_fp), .mem_we(mem_we_fp), .mem_addr(mem_addr_fp), .mem_wdata(mem_wdata_fp),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy_fp), .grant_id(grant_id_fp), .err_timeout(err_fp), .err_clr(err_clr)
  );

  // FRAM model: done pulses mem_lat cycles after the start pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      rcnt     <= 0;
      mem_done <= 1'b0;
    end else if (mem_start) begin
      rcnt     <= mem_lat;
      mem_done <= 1'b0;
    end else if (rcnt > 0) begin
      rcnt     <= rcnt - 1;
      mem_done <= (rcnt == 1);
    end else begin
      mem_done <= 1'b0;
    end
  end
  assign mem_rdata = mem_done ? rd_val : 16'h0BAD;

  // Transaction monitor, sampling pre-edge values.
  always @(posedge clk) begin
    if (mem_start) begin
      starts     <= starts + 1;
      last_addr  <= mem_addr;
      last_we    <= mem_we;
      last_wdata <= mem_wdata;
      gq.push_back(grant_id);
    end
    if (mem_start_fp) gq_fp.push_back(grant_id_fp);
    ack0s <= ack0s + int'(ack0);
    ack1s <= ack1s + int'(ack1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int port, input int lim, output int it);
    it = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        it = i;
        break;
      end
    end
    chk("ack_seen", 32'(it != 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int it, s0, a0, a1, n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ack0", ack0, 0);           chk("rst_ack1", ack1, 0);
    chk("rst_start", mem_start, 0);     chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);       chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);       chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);           chk("rst_gid", grant_id, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read, port 0
    s0 = starts; a0 = ack0s; a1 = ack1s;
    req0 = 1; addr0 = 16'h0012; we0 = 0; mem_lat = 5; rd_val = 16'hBEEF;
    @(negedge clk);
    chk("t1_start", mem_start, 1);      chk("t1_busy", busy, 1);
    chk("t1_gid", grant_id, 0);
    wait_ack(0, 6, it);
    req0 = 0;
    chk("t1_lat", it, 6);
    chk("t1_rdata0", rdata0, 16'hBEEF); chk("t1_ack1", ack1, 0);
    repeat (3) @(negedge clk);
    chk("t1_starts", starts - s0, 1);   chk("t1_ack0n", ack0s - a0, 1);
    chk("t1_ack1n", ack1s - a1, 0);     chk("t1_addr", last_addr, 16'h0012);
    chk("t1_we", last_we, 0);           chk("t1_rdata0_hold", rdata0, 16'hBEEF);
    chk("t1_busy_idle", busy, 0);

    // Single write, port 1
    s0 = starts; a0 = ack0s; a1 = ack1s;
    req1 = 1; addr1 = 16'h0100; wdata1 = 16'h7FFF; we1 = 1; rd_val = 16'h1234;
    wait_ack(1, 20, it);
    req1 = 0;
    repeat (3) @(negedge clk);
    chk("t2_we", last_we, 1);           chk("t2_wdata", last_wdata, 16'h7FFF);
    chk("t2_addr", last_addr, 16'h0100);
    chk("t2_ack1n", ack1s - a1, 1);     chk("t2_ack0n", ack0s - a0, 0);
    chk("t2_rdata1", rdata1, 16'h0000); chk("t2_rdata0", rdata0, 16'hBEEF);
    chk("t2_gid", grant_id, 1);

    // Both ports held for four transactions
    gq.delete(); gq_fp.delete();
    mem_lat = 3;
    req0 = 1; req1 = 1; n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n += int'(ack0) + int'(ack1);
      if (n == 4) begin
        req0 = 0; req1 = 0;
        break;
      end
    end
    chk("t3_acks", n, 4);
    repeat (3) @(negedge clk);
    chk("t3_len", gq.size(), 4);
    chk("t3_g0", gq[0], 0); chk("t3_g1", gq[1], 1);
    chk("t3_g2", gq[2], 0); chk("t3_g3", gq[3], 1);
    chk("t3_fp_len", gq_fp.size(), 4);
    chk("t3_fp0", gq_fp[0], 0); chk("t3_fp1", gq_fp[1], 0);
    chk("t3_fp2", gq_fp[2], 0); chk("t3_fp3", gq_fp[3], 0);

    // Request dropped and address changed while waiting
    s0 = starts; a0 = ack0s;
    mem_lat = 5; rd_val = 16'hA5A5;
    req0 = 1; addr0 = 16'h0055; we0 = 0;
    repeat (2) @(negedge clk);
    req0 = 0; addr0 = 16'h0077; we0 = 1;
    wait_ack(0, 20, it);
    repeat (6) @(negedge clk);
    chk("t4_addr", last_addr, 16'h0055); chk("t4_we", last_we, 0);
    chk("t4_starts", starts - s0, 1);    chk("t4_ack0n", ack0s - a0, 1);
    chk("t4_rdata0", rdata0, 16'hA5A5);

    // Timeout: done withheld 20 cycles, clear coinciding with the set
    mem_lat = 20; rd_val = 16'hC0DE;
    req1 = 1; addr1 = 16'h0200; we1 = 0; it = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk("t5_err_before", err_timeout, 0);
        err_clr = 1;
      end
      if (i == 10) begin
        chk("t5_err_set", err_timeout, 1);
        chk("t5_busy_wait", busy, 1);
        err_clr = 0;
      end
      if (ack1) begin
        it = i;
        req1 = 0;
        break;
      end
    end
    chk("t5_lat", it, 22);
    chk("t5_rdata1", rdata1, 16'hC0DE);
    chk("t5_err_sticky", err_timeout, 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("t5_err_clr", err_timeout, 0);

    // Reset asserted while waiting
    mem_lat = 10; rd_val = 16'h5555;
    req0 = 1; addr0 = 16'h0300; we0 = 0;
    repeat (4) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    req0 = 0; rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);            chk("t6_ack0", ack0, 0);
    chk("t6_start", mem_start, 0);      chk("t6_addr", mem_addr, 0);
    chk("t6_wdata", mem_wdata, 0);      chk("t6_we", mem_we, 0);
    chk("t6_rdata0", rdata0, 0);        chk("t6_rdata1", rdata1, 0);
    chk("t6_gid", grant_id, 0);         chk("t6_err", err_timeout, 0);
    s0 = starts; a0 = ack0s; a1 = ack1s;
    @(negedge clk); rst_n = 1;
    repeat (15) @(negedge clk);
    chk("t6_starts", starts - s0, 0);
    chk("t6_ack0n", ack0s - a0, 0);     chk("t6_ack1n", ack1s - a1, 0);

    // First tie after reset goes to port 0, then port 1
    mem_lat = 2;
    req0 = 1; req1 = 1; addr0 = 16'h0001; addr1 = 16'h0002; we0 = 0; we1 = 0;
    @(negedge clk);
    chk("t7_gid0", grant_id, 0);        chk("t7_addr0", mem_addr, 16'h0001);
    wait_ack(0, 10, it);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_gid1", grant_id, 1);        chk("t7_addr1", mem_addr, 16'h0002);
    wait_ack(1, 10, it);
    req1 = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fram_arbiter.md
# fram_arbiter

Two-port arbiter that shares the single SPI FRAM port between the SUBLEQ CPU core (port 0) and a secondary master (port 1), such as a UART program loader or debug port. It grants one whole FRAM transaction at a time, latches that transaction's address, data and direction, and drives the FRAM interface with a one-cycle start pulse. It returns read data and a one-cycle acknowledge to the owning port. The arbiter sits between the CPU and the SPI FRAM interface and does not modify that interface's protocol.

## Interface
- AW, 16, address width
- DW, 16, data word width
- FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 always wins
- TIMEOUT, 4096, cycles in WAIT before timeout flag; 0 disables the timeout
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  transaction request, level; held until ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid with ack, held until that port's next ack
- mem_start  out  1  one-cycle start pulse to the FRAM interface
- mem_we  out  1  latched direction
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_done  in  1  FRAM transfer complete; sampled as a pulse
- mem_rdata  in  DW  FRAM read data, valid when mem_done = 1
- busy  out  1  high in every state except IDLE
- grant_id  out  1  index of the current or last granted port
- err_timeout  out  1  sticky timeout flag
- err_clr  in  1  clears err_timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick a winner and latch its we/addr/wdata into the mem_* registers.
  - Set grant_id to the winner and go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: mem_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - Stay until mem_done = 1.
  - On mem_done: capture mem_rdata into rdata[grant_id] for reads only (writes leave rdata unchanged); go to RESP.
- RESP: ack[grant_id] = 1 for one cycle; go to IDLE.
- Arbitration:
  - With FIXED_PRIO = 1, port 0 wins whenever req0 = 1.
  - With FIXED_PRIO = 0, the port not granted last wins a tie. A lone requester always wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- Requests:
  - Request inputs are sampled only in IDLE.
  - A req drop or change of addr/wdata/we during ISSUE, WAIT or RESP is ignored; the latched transaction completes.
  - A requester must drop req on the edge at which it sees ack. A req still high in the following IDLE is a new transaction.
- Timeout:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT (TIMEOUT ≠ 0), set err_timeout.
  - The FSM keeps waiting; there is no abort.
  - The counter saturates at TIMEOUT.
  - err_clr clears the flag. If err_clr and the set condition occur in the same cycle, set wins.
- mem_done seen outside WAIT is ignored.

## Timing
- Reset values: state IDLE, all ack 0, mem_start 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata0/1 0, busy 0, grant_id 0, err_timeout 0, last_grant 1.
- All outputs are registered.
- req high in IDLE cycle T gives mem_start high in T+1.
- mem_done high in cycle D gives ack and rdata valid in D+1.
- Minimum spacing between consecutive mem_start pulses is mem latency + 3 cycles.
- If both ports request continuously with FIXED_PRIO = 0, grants strictly alternate.
- Reset mid-transaction returns to IDLE immediately. No ack is issued, and the outstanding FRAM transfer is abandoned; the FRAM interface shares rst_n.

## Structure
- Package fram_arb_pkg holds:
  - the state enum (2-bit encoding);
  - the PORT_CPU = 0 and PORT_AUX = 1 constants.
- The winner pick is a pure function in the package; no sub-module.
- Single module fram_arbiter: FSM, latch registers, per-port rdata registers, wait counter sized $clog2(TIMEOUT+1) with a minimum width of 1.

## Test plan
- Single read, port 0: addr0 = 0x0012, mem_done returns 0xBEEF after 5 cycles -> one mem_start pulse with mem_addr = 0x0012 and mem_we = 0; ack0 one cycle, rdata0 = 0xBEEF; ack1 stays 0.
- Single write, port 1: addr1 = 0x0100, wdata1 = 0x7FFF -> mem_we = 1, mem_wdata = 0x7FFF; ack1 pulses; rdata1 unchanged at 0.
- Simultaneous req0/req1 held through 4 transactions, round-robin -> grant order 0, 1, 0, 1. With FIXED_PRIO = 1 -> order 0, 0, 0, 0 while req1 starves.
- req0 dropped and addr0 changed during WAIT -> the original address completes and ack0 still pulses once.
- TIMEOUT = 8, mem_done withheld 20 cycles -> err_timeout rises on the 8th WAIT cycle, completes normally when done arrives, then clears on err_clr.
- rst_n asserted during WAIT -> all outputs return to reset values immediately; no ack is issued after release.
